// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG core: FSM encoding, parameter defaults and
// the width of the repetition-count run counter.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FAIL    = 2'd2
  } trng_state_e;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_LANES     = 4;
  localparam int unsigned DEF_REP_LIMIT = 32;

  // Wide enough for any REP_LIMIT up to 255.
  localparam int unsigned RUN_BITS = 8;

endpackage

// File: rtl/trng_health.sv
// Repetition-count health test: trips when REP_LIMIT consecutive identical
// samples are seen. A run counter of zero means no previous sample exists yet.
module trng_health
  import trng_pkg::*;
#(
  parameter int unsigned REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic sample_en,
  output logic trip
);

  logic [RUN_BITS-1:0] run;
  logic [RUN_BITS-1:0] run_next;
  logic                prev;

  always_comb begin
    run_next = run;
    if (run == '0 || sample != prev) begin
      run_next = RUN_BITS'(1);
    end else if (run != '1) begin
      run_next = run + RUN_BITS'(1);
    end
  end

  assign trip = sample_en && (run_next >= RUN_BITS'(REP_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= '0;
      prev <= 1'b0;
    end else if (sample_en) begin
      run  <= run_next;
      prev <= sample;
    end
  end

endmodule

// File: rtl/trng_core.sv
// TRNG core: synchronised oscillator lanes folded by XOR, von Neumann debiased
// into a word accumulator, with a valid/ready output and a sticky health trip.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | not collecting; accumulator and count retained
//   ST_COLLECT | one folded sample per cycle, pairs debiased into the word
//   ST_FAIL    | health test tripped; outputs forced quiet until rst
module trng_core
  import trng_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enabled,
  input  logic [LANES-1:0] entropy_in,
  input  logic             ready,
  output logic [WIDTH-1:0] number,
  output logic             valid,
  output logic             health_fail
);

  localparam int unsigned CNT_BITS = $clog2(WIDTH + 1);

  trng_state_e         state;
  trng_state_e         state_next;
  logic [LANES-1:0]    sync1;
  logic [LANES-1:0]    sync2;
  logic                f;
  logic                phase;
  logic                first_bit;
  logic                trip;
  logic                health_clr;
  logic                collecting;
  logic                yield;
  logic                full;
  logic                load;
  logic                accept;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    number_q;
  logic [CNT_BITS-1:0] count;

  assign f          = ^sync2;
  assign collecting = (state == ST_COLLECT) && !trip;
  assign yield      = collecting && phase && (first_bit != f);
  assign full       = (count == CNT_BITS'(WIDTH));
  // A full word may transfer out of IDLE as well; only FAIL (or its entry) blocks it.
  assign load       = full && (!valid || ready) && (state != ST_FAIL) && !trip;
  assign accept     = yield && (!full || load);
  assign health_clr = rst || (state == ST_IDLE);

  trng_health #(
    .REP_LIMIT(REP_LIMIT)
  ) u_health (
    .clk      (clk),
    .rst      (health_clr),
    .sample   (f),
    .sample_en(state == ST_COLLECT),
    .trip     (trip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enabled) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (trip)          state_next = ST_FAIL;
        else if (!enabled) state_next = ST_IDLE;
      end
      ST_FAIL: state_next = ST_FAIL;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      phase     <= 1'b0;
      first_bit <= 1'b0;
      acc       <= '0;
      count     <= '0;
      number_q  <= '0;
      valid     <= 1'b0;
    end else begin
      sync1 <= entropy_in;
      sync2 <= sync1;

      if (collecting) begin
        phase <= ~phase;
        if (!phase) first_bit <= f;
      end else begin
        phase <= 1'b0;
      end

      if (load) begin
        number_q <= acc;
        count    <= accept ? CNT_BITS'(1) : '0;
      end else if (accept) begin
        count <= count + CNT_BITS'(1);
      end

      // The debiased bit of a (0,1)/(1,0) pair equals its first sample.
      if (accept) acc <= {acc[WIDTH-2:0], first_bit};

      if (trip || state == ST_FAIL) valid <= 1'b0;
      else if (load)                valid <= 1'b1;
      else if (ready)               valid <= 1'b0;
    end
  end

  assign number      = (state == ST_FAIL) ? '0 : number_q;
  assign health_fail = (state == ST_FAIL);

endmodule
